// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// State encoding and counter sizing live here so top and bench agree.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter width for n steps; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit subtract cell with borrow in/out.
module serial_sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bw_in,
  output logic [DIGIT-1:0] d_o,
  output logic             bw_out
);

  logic [DIGIT:0] diff;

  // One extra bit captures the borrow as the sign of the widened difference.
  assign diff   = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, bw_in};
  assign d_o    = diff[DIGIT-1:0];
  assign bw_out = diff[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: y = a - b - bw, DIGIT bits per clock, LSB first,
// with valid/ready handshakes on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bw_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             bw_o
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = cnt_width(N);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  y_q;
  logic              bw_q;
  logic              out_valid_q;
  logic [CntW-1:0]   cnt_q;
  logic [DIGIT-1:0]  digit_d;
  logic              digit_bw;

  serial_sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d    (a_q[DIGIT-1:0]),
    .b_d    (b_q[DIGIT-1:0]),
    .bw_in  (bw_q),
    .d_o    (digit_d),
    .bw_out (digit_bw)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      bw_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Operands are only sampled on acceptance, so idle-time X never reaches state.
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            bw_q    <= bw_i;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          y_q   <= WIDTH'({digit_d, y_q} >> DIGIT);
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          bw_q  <= digit_bw;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle) && !rst_i;
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign bw_o        = bw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, handshake corners and
// randomized operations against an integer-arithmetic reference.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid, in_valid2, in_valid4;
  logic       out_ready;
  logic [7:0] a, b;
  logic       bw;
  logic       in_ready, out_valid, bw_o;
  logic [7:0] y_o;
  logic       in_ready2, out_valid2, bw_o2;
  logic [7:0] y_o2;
  logic       in_ready4, out_valid4, bw_o4;
  logic [7:0] y_o4;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .bw_i(bw), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y_o), .bw_o(bw_o)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .a_i(a), .b_i(b), .bw_i(bw), .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .y_o(y_o2), .bw_o(bw_o2)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .a_i(a), .b_i(b), .bw_i(bw), .out_valid_o(out_valid4), .out_ready_i(1'b1),
    .y_o(y_o4), .bw_o(bw_o4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer difference, borrow iff negative, result wrapped to 8 bits.
  task automatic ref_sub(input int ra, input int rb, input int rbw,
                         output logic [7:0] ry, output logic rbwo);
    int d;
    d    = ra - rb - rbw;
    rbwo = (d < 0);
    ry   = 8'((d + 512) % 256);
  endtask

  // One operation on the DIGIT=1 instance with out_ready assumed high.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic obw,
                        output logic [7:0] oy, output logic obwo, output int lat,
                        output int rdy_hi);
    int guard;
    guard  = 0;
    rdy_hi = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = oa; b = ob; bw = obw; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bw = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_hi++;
    end
    oy   = y_o;
    obwo = bw_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || in_ready2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, in_ready2);
    end
    checks++;
    if (out_valid !== 1'b0 || y_o !== 8'd0 || bw_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b y=%0d bw=%b want 0 0 0", out_valid, y_o, bw_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero;
    logic [7:0] y;
    logic bo;
    int lat, rh;
    out_ready = 1'b1;
    run_op(8'd0, 8'd0, 1'b0, y, bo, lat, rh);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 8", lat);
    end
    checks++;
    if (y !== 8'd0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got y=%0d bw=%b want 0 0", y, bo);
    end
    checks++;
    if (rh !== 0) begin
      errors++;
      $display("FAIL zero_in_ready_busy: high for %0d cycles want 0", rh);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [6] = '{8'd3, 8'd255, 8'd100, 8'd0, 8'd0, 8'd90};
    logic [7:0] vb [6] = '{8'd1, 8'd0, 8'd155, 8'd255, 8'd1, 8'd90};
    logic       vc [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] wy [6] = '{8'd1, 8'd254, 8'd201, 8'd0, 8'd255, 8'd255};
    logic       wb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] y;
    logic bo;
    int lat, rh;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], y, bo, lat, rh);
      checks++;
      if (y !== wy[i] || bo !== wb[i] || lat !== 8) begin
        errors++;
        $display("FAIL vector_%0d: got y=%0d bw=%b lat=%0d want y=%0d bw=%b lat=8",
                 i, y, bo, lat, wy[i], wb[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int guard, cyc, rh;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    a = 8'd77; b = 8'd33; bw = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    // Second request stays asserted through RUN and DONE.
    a = 8'd10; b = 8'd20; bw = 1'b0;
    cyc = 0;
    rh  = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (in_ready) rh++;
    end
    checks++;
    if (cyc !== 8 || y_o !== 8'd43 || bw_o !== 1'b0 || rh !== 0) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d y=%0d bw=%b rdy=%0d want 8 43 0 0",
               cyc, y_o, bw_o, rh);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y_o !== 8'd43 || bw_o !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b y=%0d bw=%b rdy=%b want 1 43 0 0",
                 i, out_valid, y_o, bw_o, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 8 || y_o !== 8'd246 || bw_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d y=%0d bw=%b want 8 246 1", cyc, y_o, bw_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] y;
    logic bo;
    int lat, rh, seen, guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = 8'd9; b = 8'd4; bw = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || y_o !== 8'd0 || bw_o !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: got valid_cycles=%0d y=%0d bw=%b rdy=%b want 0 0 0 1",
               seen, y_o, bw_o, in_ready);
    end
    run_op(8'd200, 8'd55, 1'b0, y, bo, lat, rh);
    checks++;
    if (y !== 8'd145 || bo !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL after_abort: got y=%0d bw=%b lat=%0d want 145 0 8", y, bo, lat);
    end
  endtask

  task automatic test_digit_variants;
    int guard, lat2, lat4;
    logic [7:0] y2, y4;
    logic b2, b4;
    guard = 0;
    while (!(in_ready2 && in_ready4) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = 8'd100; b = 8'd155; bw = 1'b0;
    in_valid2 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0; in_valid4 = 1'b0;
    lat2 = -1; lat4 = -1;
    y2 = '0; y4 = '0; b2 = 1'b0; b4 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (out_valid2 && lat2 < 0) begin lat2 = cyc; y2 = y_o2; b2 = bw_o2; end
      if (out_valid4 && lat4 < 0) begin lat4 = cyc; y4 = y_o4; b4 = bw_o4; end
    end
    checks++;
    if (lat2 !== 4 || y2 !== 8'd201 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL digit2: got lat=%0d y=%0d bw=%b want 4 201 1", lat2, y2, b2);
    end
    checks++;
    if (lat4 !== 2 || y4 !== 8'd201 || b4 !== 1'b1) begin
      errors++;
      $display("FAIL digit4: got lat=%0d y=%0d bw=%b want 2 201 1", lat4, y4, b4);
    end
  endtask

  task automatic test_random;
    logic [7:0] ra, rb, y, wy;
    logic rbw, bo, wbo;
    logic [8:0] sum;
    int lat, rh;
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbw = 1'($urandom);
      run_op(ra, rb, rbw, y, bo, lat, rh);
      ref_sub(int'(ra), int'(rb), int'(rbw), wy, wbo);
      checks++;
      if (y !== wy || bo !== wbo || lat !== 8) begin
        errors++;
        $display("FAIL random_%0d: %0d-%0d-%0d got y=%0d bw=%b lat=%0d want y=%0d bw=%b lat=8",
                 i, ra, rb, rbw, y, bo, lat, wy, wbo);
      end
      // Adding back b and bw must reproduce a, with carry matching the borrow.
      sum = {1'b0, y} + {1'b0, rb} + {8'd0, rbw};
      checks++;
      if (sum[7:0] !== ra || sum[8] !== bo) begin
        errors++;
        $display("FAIL compose_%0d: got a=%0d cy=%b want a=%0d cy=%b",
                 i, sum[7:0], sum[8], ra, bo);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; bw = 1'b0;
    test_reset();
    test_zero();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_digit_variants();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
